// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU execution controller.
// Holds the opcode map, controller state encoding and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_ADC  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RA_HI  = 7;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes 1..9 write rd; ADC is added by the controller when carry is built in.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic op_sets_zero(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execution controller.
// Bit 8 of the internal result carries carry-out / borrow / shifted-out bit.
module exec_alu
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] result,
  output logic       zero,
  output logic       co
);

  logic [8:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_LDI:  wide = {1'b0, b};
      OP_MOV:  wide = {1'b0, a};
      OP_SHL:  wide = {a[7], a[6:0], 1'b0};
      OP_SHR:  wide = {a[0], 1'b0, a[7:1]};
      OP_ADC:  wide = {1'b0, a} + {1'b0, b} + {8'b0, ci};
      default: wide = '0;
    endcase
  end

  assign result = wide[7:0];
  assign zero   = (wide[7:0] == 8'd0);
  assign co     = wide[8];

endmodule

// File: rtl/exec_ctrl.sv
// Three-cycle fetch/decode/execute controller for the 8-bit CPU.
// Optional carry flag and ADC opcode are built in when EXEC_CTRL_CARRY_EN is defined.
module exec_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  output logic [3:0]      src0,
  output logic [3:0]      src1,
  input  logic [7:0]      data0,
  input  logic [7:0]      data1,
  output logic            we,
  output logic [3:0]      dst,
  output logic [7:0]      data,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            halted
);

  // state     | meaning
  // ST_IDLE   | waiting for run
  // ST_FETCH  | pc on the ROM bus
  // ST_DECODE | ROM data valid, latched into ir
  // ST_EXEC   | selects/write port driven from ir, pc advances
  // ST_HALT   | terminal until reset

  state_t          state, state_nxt;
  logic [15:0]     ir;
  logic [3:0]      op, rd, ra, rb;
  logic [7:0]      imm, alu_b, alu_res;
  logic            alu_zero, alu_co, c_in;
  logic            writes, flag_upd, z, z_nxt;
  logic [PC_W-1:0] pc_nxt;

  assign op  = ir[OPC_HI:OPC_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign ra  = ir[RA_HI:RA_LO];
  assign rb  = ir[RB_HI:RB_LO];
  assign imm = ir[IMM_HI:IMM_LO];

  assign alu_b = (op == OP_LDI) ? imm : data1;

  exec_alu u_alu (
    .op     (op),
    .a      (data0),
    .b      (alu_b),
    .ci     (c_in),
    .result (alu_res),
    .zero   (alu_zero),
    .co     (alu_co)
  );

`ifdef EXEC_CTRL_CARRY_EN
  logic c;
  logic carry_upd;

  assign c_in      = c;
  assign writes    = op_writes(op) || (op == OP_ADC);
  assign flag_upd  = op_sets_zero(op) || (op == OP_ADC);
  assign carry_upd = (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) ||
                     (op == OP_SHR) || (op == OP_ADC);

  always_ff @(posedge clk) begin
    if (!rst_n) c <= 1'b0;
    else if ((state == ST_EXEC) && carry_upd) c <= alu_co;
  end
`else
  logic unused_co;

  assign c_in      = 1'b0;
  assign writes    = op_writes(op);
  assign flag_upd  = op_sets_zero(op);
  assign unused_co = alu_co;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = (op == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // rst_n gates we so an aborted instruction cannot write on the reset edge.
  always_comb begin
    src0   = (op == OP_JZ) ? rd : ra;
    src1   = rb;
    dst    = rd;
    data   = alu_res;
    we     = (state == ST_EXEC) && writes && rst_n;
    halted = (state == ST_HALT);
  end

  always_comb begin
    pc_nxt = pc + PC_W'(1);
    if ((op == OP_JMP) || ((op == OP_JZ) && (data0 == 8'd0))) pc_nxt = PC_W'(imm);
  end

  assign z_nxt = ((state == ST_EXEC) && flag_upd) ? alu_zero : z;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= '0;
      z         <= 1'b0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      z         <= z_nxt;
      if (state == ST_DECODE) ir <= instr;
      if (state == ST_EXEC) begin
        pc <= pc_nxt;
        if (op == OP_OUT) begin
          out_data  <= data0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
